// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  // Response data returned for write transfers.
  localparam logic [APB_DATA_W-1:0] WRITE_RSP_RDATA = '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles without pready; hit_o flags the increment that reaches TIMEOUT_CYCLES.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  assign w_count_next = r_count + CNT_W'(1);
  assign hit_o        = inc_i && (w_count_next == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clear_i || hit_o) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB master, one transfer at a time.
// Optional ACCESS timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_slverr_o,
  output logic              psel_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic              penable_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_master_state_e r_state, w_state_next;

  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_slverr;

  logic w_cmd_fire;
  logic w_access_done;
  logic w_timeout_hit;

  assign w_cmd_fire    = (r_state == IDLE) && cmd_valid_i;
  assign w_access_done = (r_state == ACCESS) && pready_i;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clear_i(r_state == SETUP),
    .inc_i  ((r_state == ACCESS) && !pready_i),
    .hit_o  (w_timeout_hit)
  );
`else
  assign w_timeout_hit = 1'b0;
`endif

  // NOTE: reset is synchronous, so it lives inside the clocked block and wins over every other branch.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (cmd_valid_i) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (pready_i || w_timeout_hit) w_state_next = RESP;
      RESP:    if (rsp_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_paddr  <= cmd_addr_i;
        r_pwrite <= cmd_write_i;
        r_pwdata <= cmd_wdata_i;
      end
      if (w_access_done) begin
        r_rsp_slverr <= pslverr_i;
        r_rsp_rdata  <= r_pwrite ? DATA_W'(WRITE_RSP_RDATA) : prdata_i;
      end else if (w_timeout_hit) begin
        r_rsp_slverr <= 1'b1;
        r_rsp_rdata  <= '0;
      end
    end
  end

  assign cmd_ready_o  = (r_state == IDLE);
  assign psel_o       = (r_state == SETUP) || (r_state == ACCESS);
  assign penable_o    = (r_state == ACCESS);
  assign rsp_valid_o  = (r_state == RESP);
  assign paddr_o      = r_paddr;
  assign pwrite_o     = r_pwrite;
  assign pwdata_o     = r_pwdata;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign rsp_slverr_o = r_rsp_slverr;

endmodule
